// File: rtl/medidor_periodo_if.sv
// medidor_periodo signal bundle: slow input, enable and measurement results.
// master drives SINALIN/ENABLE; slave is the period meter.
interface medidor_periodo_if #(
    parameter int WIDTH = 27
);
    logic             SINALIN;
    logic             ENABLE;
    logic             PULSO;
    logic             VALIDO;
    logic [WIDTH-1:0] PERIODO;
    logic             TIMEOUT_FLAG;

    modport master (
        output SINALIN,
        output ENABLE,
        input  PULSO,
        input  VALIDO,
        input  PERIODO,
        input  TIMEOUT_FLAG
    );

    modport slave (
        input  SINALIN,
        input  ENABLE,
        output PULSO,
        output VALIDO,
        output PERIODO,
        output TIMEOUT_FLAG
    );
endinterface

// File: rtl/medidor_periodo.sv
// Period meter for a slow async square wave: sync, edge tick, period, loss flag.
// Optional glitch filter before the edge detector: define FILTRO_EN.
module medidor_periodo #(
    parameter int               WIDTH       = 27,
    parameter logic [WIDTH-1:0] TIMEOUT     = WIDTH'(100000000),
    parameter int               SYNC_STAGES = 2,
    parameter int               FILTRO_LEN  = 4
) (
    input  logic              CLOCKIN,
    input  logic              RESET,
    medidor_periodo_if.slave  bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] STALL   = 2'd3;

    localparam logic [WIDTH-1:0] TLAST = TIMEOUT - WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   nivel;
    logic [1:0]             edge_q;
    logic                   rise;
    logic [1:0]             estado;
    logic [WIDTH-1:0]       contador;

    // Bring SINALIN into the CLOCKIN domain
    always_ff @(posedge CLOCKIN or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.SINALIN};
        end
    end

`ifdef FILTRO_EN
    localparam int FW = (FILTRO_LEN > 1) ? $clog2(FILTRO_LEN) : 1;

    logic          filt_q;
    logic [FW-1:0] filt_cnt;

    // Accept a level change only after FILTRO_LEN stable cycles
    always_ff @(posedge CLOCKIN or posedge RESET) begin
        if (RESET) begin
            filt_q   <= 1'b0;
            filt_cnt <= '0;
        end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (filt_cnt == FW'(FILTRO_LEN - 1)) begin
                filt_q   <= sync_q[SYNC_STAGES-1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    assign nivel = filt_q;
`else
    assign nivel = sync_q[SYNC_STAGES-1];
`endif

    // Current and previous level for rising-edge detection
    always_ff @(posedge CLOCKIN or posedge RESET) begin
        if (RESET) begin
            edge_q <= 2'b00;
        end else begin
            edge_q <= {edge_q[0], nivel};
        end
    end

    assign rise = edge_q[0] & ~edge_q[1];

    // Measurement FSM, period counter and registered outputs
    always_ff @(posedge CLOCKIN or posedge RESET) begin
        if (RESET) begin
            estado           <= IDLE;
            contador         <= '0;
            bus.PULSO        <= 1'b0;
            bus.VALIDO       <= 1'b0;
            bus.PERIODO      <= '0;
            bus.TIMEOUT_FLAG <= 1'b0;
        end else begin
            bus.PULSO  <= rise && (estado != IDLE);
            bus.VALIDO <= 1'b0;
            if (!bus.ENABLE) begin
                estado           <= IDLE;
                contador         <= '0;
                bus.TIMEOUT_FLAG <= 1'b0;
            end else begin
                unique case (estado)
                    IDLE: begin
                        contador         <= '0;
                        bus.TIMEOUT_FLAG <= 1'b0;
                        estado           <= ARMED;
                    end
                    ARMED: begin
                        contador <= '0;
                        if (rise) begin
                            estado <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            bus.PERIODO <= contador + WIDTH'(1);
                            bus.VALIDO  <= 1'b1;
                            contador    <= '0;
                        end else if (contador == TLAST) begin
                            estado           <= STALL;
                            bus.TIMEOUT_FLAG <= 1'b1;
                        end else begin
                            contador <= contador + WIDTH'(1);
                        end
                    end
                    STALL: begin
                        if (rise) begin
                            bus.TIMEOUT_FLAG <= 1'b0;
                            contador         <= '0;
                            estado           <= MEASURE;
                        end
                    end
                    default: begin
                        estado <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_medidor_periodo.sv
// Directed bench for medidor_periodo with TIMEOUT=50.
// Edge, period, timeout, enable, glitch and reset behaviour.
module tb_medidor_periodo;

    localparam int W = 27;

`ifdef FILTRO_EN
    localparam int FLAT = 4;
    localparam int GLITCH_PULSES = 0;
`else
    localparam int FLAT = 0;
    localparam int GLITCH_PULSES = 1;
`endif

    logic CLOCKIN;
    logic RESET;

    medidor_periodo_if #(.WIDTH(W)) bus ();

    medidor_periodo #(
        .WIDTH(W),
        .TIMEOUT(27'd50),
        .SYNC_STAGES(2),
        .FILTRO_LEN(4)
    ) dut (
        .CLOCKIN(CLOCKIN),
        .RESET(RESET),
        .bus(bus.slave)
    );

    initial CLOCKIN = 1'b0;
    always #5 CLOCKIN = ~CLOCKIN;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int npulse = 0;
    int nvalid = 0;
    int nflag = 0;
    int last_pulse = 0;
    int flag_rise = 0;
    int flag_fall = 0;
    int last_per = 0;
    logic prev_flag = 1'b0;

    // Event monitor, sampled 1 time unit after each rising edge
    always @(posedge CLOCKIN) begin
        cyc = cyc + 1;
        #1;
        if (bus.PULSO) begin
            npulse = npulse + 1;
            last_pulse = cyc;
        end
        if (bus.VALIDO) begin
            nvalid = nvalid + 1;
            last_per = int'(bus.PERIODO);
        end
        if (bus.TIMEOUT_FLAG && !prev_flag) begin
            nflag = nflag + 1;
            flag_rise = cyc;
        end
        if (!bus.TIMEOUT_FLAG && prev_flag) begin
            flag_fall = cyc;
        end
        prev_flag = bus.TIMEOUT_FLAG;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.SINALIN = v;
        repeat (n) @(negedge CLOCKIN);
    endtask

    task automatic wave(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, p / 2);
            hold(1'b0, p - p / 2);
        end
    endtask

    int p0;
    int v0;
    int f0;
    int d0;
    int per0;

    initial begin
        RESET = 1'b1;
        bus.SINALIN = 1'b0;
        bus.ENABLE = 1'b0;
        repeat (3) @(negedge CLOCKIN);
        check("rst_pulso", int'(bus.PULSO), 0);
        check("rst_valido", int'(bus.VALIDO), 0);
        check("rst_periodo", int'(bus.PERIODO), 0);
        check("rst_flag", int'(bus.TIMEOUT_FLAG), 0);
        RESET = 1'b0;

        // idle: edges ignored while disabled
        p0 = npulse;
        wave(10, 2);
        check("idle_pulses", npulse - p0, 0);

        // steady period 10 then 37
        bus.ENABLE = 1'b1;
        hold(1'b0, 3);
        p0 = npulse;
        v0 = nvalid;
        wave(10, 5);
        check("p10_pulses", npulse - p0, 5);
        check("p10_valids", nvalid - v0, 4);
        check("p10_periodo", last_per, 10);
        v0 = nvalid;
        wave(37, 3);
        check("p37_valids", nvalid - v0, 3);
        check("p37_periodo", last_per, 37);

        // loss of signal
        hold(1'b0, 60);
        check("to_flag", int'(bus.TIMEOUT_FLAG), 1);
        check("to_delay", flag_rise - last_pulse, 50);
        v0 = nvalid;
        wave(10, 1);
        check("rearm_flag", int'(bus.TIMEOUT_FLAG), 0);
        check("rearm_novalid", nvalid - v0, 0);
        check("rearm_fall", flag_fall, last_pulse);
        wave(10, 1);
        check("rearm_valid", nvalid - v0, 1);
        check("rearm_periodo", last_per, 10);

        // boundary: 50 measures, 51 stalls
        v0 = nvalid;
        f0 = nflag;
        wave(50, 4);
        check("b50_valids", nvalid - v0, 4);
        check("b50_periodo", last_per, 50);
        check("b50_noflag", nflag - f0, 0);
        v0 = nvalid;
        wave(51, 2);
        check("b51_flag", nflag - f0, 1);
        check("b51_valids", nvalid - v0, 1);
        check("b51_periodo", last_per, 50);

        // enable drop while stalled
        hold(1'b0, 60);
        check("en_flag_set", int'(bus.TIMEOUT_FLAG), 1);
        per0 = int'(bus.PERIODO);
        v0 = nvalid;
        bus.ENABLE = 1'b0;
        @(posedge CLOCKIN);
        #2;
        check("en_flag_clr", int'(bus.TIMEOUT_FLAG), 0);
        check("en_periodo", int'(bus.PERIODO), per0);
        check("en_novalid", nvalid - v0, 0);
        @(negedge CLOCKIN);
        bus.ENABLE = 1'b1;
        wave(10, 1);
        check("reen_first", nvalid - v0, 0);
        wave(10, 1);
        check("reen_second", nvalid - v0, 1);
        check("reen_periodo", last_per, 10);

        // short glitch and edge latency
        hold(1'b0, 10);
        p0 = npulse;
        hold(1'b1, 2);
        hold(1'b0, 20);
        check("glitch_pulses", npulse - p0, GLITCH_PULSES);
        p0 = npulse;
        d0 = cyc;
        hold(1'b1, 6);
        hold(1'b0, 20);
        check("wide_pulses", npulse - p0, 1);
        check("latency", last_pulse - d0, 4 + FLAT);

        // async reset mid-measurement
        wave(10, 3);
        hold(1'b1, 2);
        #2;
        RESET = 1'b1;
        #1;
        check("amid_pulso", int'(bus.PULSO), 0);
        check("amid_valido", int'(bus.VALIDO), 0);
        check("amid_periodo", int'(bus.PERIODO), 0);
        check("amid_flag", int'(bus.TIMEOUT_FLAG), 0);
        @(negedge CLOCKIN);
        RESET = 1'b0;
        hold(1'b0, 5);
        v0 = nvalid;
        wave(10, 1);
        check("post_rst_first", nvalid - v0, 0);
        wave(10, 1);
        check("post_rst_valid", nvalid - v0, 1);
        check("post_rst_per", last_per, 10);
        hold(1'b0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/medidor_periodo.md
# medidor_periodo

Period meter for a slow, asynchronous square wave (e.g. a divided clock or a sensor tick) in the CLOCKIN domain. It does four things:
- Synchronizes the input.
- Detects its rising edges and emits a one-cycle tick per edge.
- Measures the edge-to-edge period in CLOCKIN cycles.
- Flags loss of signal.

It is the receiving end of the frequency-divider path: it turns a slow clock back into single-cycle enables and a checked period for the control logic.

## Interface
- WIDTH, 27: width of period counter and PERIODO.
- TIMEOUT, 27'd100000000: cycles without a rising edge before loss of signal (2 s at 50 MHz). Must satisfy 2 ≤ TIMEOUT ≤ 2^WIDTH−1.
- SYNC_STAGES, 2: synchronizer flops on SINALIN, ≥2.
- FILTRO_LEN, 4: glitch-filter length in cycles. Used only with FILTRO_EN.

- CLOCKIN  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- SINALIN  in  1  asynchronous slow input signal.
- ENABLE  in  1  measurement enable, synchronous to CLOCKIN.
- PULSO  out  1  one-cycle pulse per accepted rising edge.
- VALIDO  out  1  one-cycle pulse, PERIODO updated this cycle.
- PERIODO  out  WIDTH  last measured period in CLOCKIN cycles.
- TIMEOUT_FLAG  out  1  level, no edge for TIMEOUT cycles.

## Operation
- **Reset:** on RESET high, immediately force the following. No other state or output exists.
  - All outputs to 0.
  - Synchronizer flops and edge register to 0.
  - contador to 0.
  - State to IDLE.
- **Edge detection:** SINALIN passes through the SYNC_STAGES chain. `rise` = synced level AND NOT previous synced level.
- **PULSO:** registered copy of `rise`. It fires in every state except IDLE.
- **IDLE:** contador held at 0, TIMEOUT_FLAG 0. Go to ARMED when ENABLE=1.
- **ARMED:** waits for the first edge. On `rise`: contador←0, go to MEASURE. No VALIDO.
- **MEASURE:**
  - On `rise`: PERIODO←contador+1, VALIDO←1, contador←0.
  - Else if contador = TIMEOUT−1: go to STALL, TIMEOUT_FLAG←1, contador held.
  - Else: contador←contador+1.
- **STALL:** TIMEOUT_FLAG stays 1. On `rise`: TIMEOUT_FLAG←0, contador←0, go to MEASURE. No VALIDO; the first edge after a stall only re-arms.
- **ENABLE low:** from any state, go to IDLE next cycle. contador←0 and TIMEOUT_FLAG←0. PERIODO keeps its last value. VALIDO is not asserted in that cycle.
- **Simultaneous events:**
  - `rise` on the cycle contador = TIMEOUT−1 in MEASURE: `rise` wins, with VALIDO and PERIODO=TIMEOUT, and no stall.
  - ENABLE low together with `rise`: ENABLE wins and there is no VALIDO. PULSO still fires.
- **Arithmetic:**
  - PERIODO = number of CLOCKIN cycles between consecutive accepted edges. A period of N cycles gives PERIODO=N.
  - contador never exceeds TIMEOUT−1, so it cannot wrap.

## Timing
- **Edge latency:** SINALIN rising is first sampled high at clock edge k. `rise` is high in the cycle after edge k+SYNC_STAGES. PULSO, VALIDO and PERIODO are registered at edge k+SYNC_STAGES+1.
  - Default: 3 cycles after first sample.
  - FILTRO_EN adds FILTRO_LEN cycles.
- **Output updates:** PULSO and VALIDO are exactly one cycle wide. PERIODO changes only on the cycle VALIDO=1.
- **Timeout timing:** TIMEOUT_FLAG rises TIMEOUT cycles after the last accepted edge in MEASURE. It falls on the cycle PULSO rises for the next edge.
- **Input limits:**
  - Minimum measurable period: 2 cycles.
  - SINALIN high and low phases must each be ≥ SYNC_STAGES cycles, otherwise edges may be lost.

## Configuration
- Macro: FILTRO_EN.
  - **Defined:** a glitch filter sits between the synchronizer and the edge detector. The filtered level changes only after the synced level has differed from it for FILTRO_LEN consecutive cycles. Pulses shorter than FILTRO_LEN produce no `rise`. Latency increases by FILTRO_LEN cycles.
  - **Undefined:** the synced level feeds the edge detector directly, and FILTRO_LEN is unused.

## Test plan
- **Reset:** assert RESET mid-MEASURE with contador≈500 → all outputs 0 in the same cycle. After release, ARMED requires a new first edge before any VALIDO.
- **Steady period:** ENABLE=1, SINALIN square wave with period 10 cycles → PULSO every 10 cycles. First edge gives no VALIDO; each later edge gives VALIDO with PERIODO=10. Then switch to period 37 → next VALIDO has PERIODO=37.
- **Timeout:** TIMEOUT=50, period 10 for 3 edges, then hold SINALIN low → TIMEOUT_FLAG=1 exactly 50 cycles after the last PULSO. Restart the input → next edge clears the flag with no VALIDO. The following edge gives VALIDO with PERIODO=10.
- **Timeout boundary:** TIMEOUT=50, period exactly 50 → VALIDO with PERIODO=50 every edge, TIMEOUT_FLAG never set. Period 51 → flag set.
- **Enable drop:** drop ENABLE mid-measurement with the flag set → flag 0 next cycle, PERIODO unchanged, no VALIDO. Re-enable → two edges needed before VALIDO.
- **Glitch filter:** FILTRO_EN, FILTRO_LEN=4, 2-cycle high glitch → no PULSO. A 6-cycle pulse → one PULSO at latency 3+4. Without FILTRO_EN, the same 2-cycle glitch → one PULSO.
